// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Results beyond the displayable range are blanked to 4'hF in every digit.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [31:0]      MAX_VAL = 32'(pow10(DIGITS) - 1);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   shift;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic               ovf_pending;
    logic [31:0]        bin_ext;

    assign bin_ext = {{(32-BIN_W){1'b0}}, bin};

    // +3 correction on all digits in parallel, from the pre-shift values
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            scratch     <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            bcd         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CONV;
                        shift       <= bin;
                        scratch     <= '0;
                        cnt         <= '0;
                        ovf_pending <= (bin_ext > MAX_VAL);
                        busy        <= 1'b1;
                    end
                end
                CONV: begin
                    scratch <= {adj[BCD_W-2:0], shift[BIN_W-1]};
                    shift   <= {shift[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_IT) state <= FIN;
                end
                FIN: begin
                    bcd   <= ovf_pending ? {DIGITS{4'hF}} : scratch;
                    ovf   <= ovf_pending;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table, multi-cycle corner
// sequences and a strided sweep against a division-based reference.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd;

    int n_vec;
    int n_err;
    int done_cnt;
    int dbl_done;
    logic done_prev;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        done_cnt  = 0;
        dbl_done  = 0;
        done_prev = 1'b0;
    end

    always @(negedge clk) begin
        if (done && done_prev) dbl_done++;
        if (done) done_cnt++;
        done_prev = done;
    end

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int x;
        if (v > 9999) return 16'hFFFF;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Start pulse, then wait (bounded) for done; counts edges after acceptance
    task automatic convert(input logic [13:0] b, output int lat, output int busy_hi,
                           output logic busy_at_done);
        int c;
        int bh;
        c  = 0;
        bh = 0;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            if (!done && busy) bh++;
        end
        lat          = c;
        busy_hi      = bh;
        busy_at_done = busy;
    endtask

    initial begin
        int   lat;
        int   bh;
        int   c;
        int   snap;
        logic bd;

        n_vec = 0;
        n_err = 0;

        tbl[0] = '{14'd1234,  16'h1234, 1'b0};
        tbl[1] = '{14'd0,     16'h0000, 1'b0};
        tbl[2] = '{14'd9999,  16'h9999, 1'b0};
        tbl[3] = '{14'd10000, 16'hFFFF, 1'b1};
        tbl[4] = '{14'd16383, 16'hFFFF, 1'b1};
        tbl[5] = '{14'd7,     16'h0007, 1'b0};
        tbl[6] = '{14'd10,    16'h0010, 1'b0};
        tbl[7] = '{14'd999,   16'h0999, 1'b0};
        tbl[8] = '{14'd5000,  16'h5000, 1'b0};
        tbl[9] = '{14'd8191,  16'h8191, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        check("reset_bcd",  32'(bcd),  32'd0);

        for (int i = 0; i < 10; i++) begin
            convert(tbl[i].bin, lat, bh, bd);
            check($sformatf("latency[%0d]", i), 32'(lat), 32'd15);
            check($sformatf("busy_hi[%0d]", i), 32'(bh), 32'd14);
            check($sformatf("busy_done[%0d]", i), 32'(bd), 32'd0);
            check($sformatf("bcd[%0d]", i), 32'(bcd), 32'(tbl[i].bcd));
            check($sformatf("ovf[%0d]", i), 32'(ovf), 32'(tbl[i].ovf));
        end

        // Start held high, bin changed mid-flight, then back-to-back accept
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(negedge clk);
        c = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 5) bin = 14'd9999;
        end
        check("b2b_lat1", 32'(c), 32'd15);
        check("b2b_bcd1", 32'(bcd), 32'h4321);
        check("b2b_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'd1);
        check("b2b_no_dbl_done", 32'(done), 32'd0);
        c = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 5) check("b2b_hold_bcd", 32'(bcd), 32'h4321);
        end
        check("b2b_lat2", 32'(c), 32'd15);
        check("b2b_bcd2", 32'(bcd), 32'h9999);
        check("b2b_ovf2", 32'(ovf), 32'd0);

        // Reset mid-conversion aborts; start during reset is ignored
        @(negedge clk);
        bin   = 14'd8888;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        snap  = done_cnt;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd",  32'(bcd),  32'd0);
        check("abort_ovf",  32'(ovf),  32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(snap));
        check("abort_idle", 32'(busy), 32'd0);
        convert(14'd8888, lat, bh, bd);
        check("after_abort_lat", 32'(lat), 32'd15);
        check("after_abort_bcd", 32'(bcd), 32'h8888);

        // Strided sweep of the input range against the reference model
        for (int v = 0; v < 16384; v += 61) begin
            convert(14'(v), lat, bh, bd);
            check($sformatf("sweep_bcd[%0d]", v), 32'(bcd), 32'(ref_bcd(v)));
            check($sformatf("sweep_ovf[%0d]", v), 32'(ovf), 32'(v > 9999));
        end
        convert(14'd16383, lat, bh, bd);
        check("sweep_bcd[16383]", 32'(bcd), 32'hFFFF);

        check("done_never_consecutive", 32'(dbl_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
